irrigation_mode_fsm: RTL and testbench

- Control stage directly upstream of the system's 4:1 output selector.
- Debounces the tank-level and field sensors.
- Runs the irrigation state machine: idle, sprinkler, drip and fault.
- Drives the 2-bit select code consumed downstream, the actuator enables and a hysteretic tank-fill valve.

---
 rtl/irrigation_mode_fsm.sv | 186 ++++++++++++++++++
 tb/tb_irrigation_mode_fsm.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_mode_fsm.sv
// rtl/irrigation_mode_fsm.sv - irrigation mode controller: sensor conditioning, mode FSM, tank fill valve
module irrigation_mode_fsm #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_ON_CYCLES   = 16,
    parameter int MAX_ON_CYCLES   = 200,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       lvl_l,
    input  logic       lvl_m,
    input  logic       lvl_h,
    input  logic       soil_dry,
    input  logic       temp_high,
    output logic [1:0] sel,
    output logic       sprinkler_en,
    output logic       drip_en,
    output logic       fill_valve,
    output logic       alarm
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SPRINKLE = 2'b01,
        ST_DRIP     = 2'b10,
        ST_FAULT    = 2'b11
    } state_t;

    localparam int NS   = 5;
    localparam int DB_W = 4;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_MAX_LAST = CNT_W'(MAX_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_MIN_LAST = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(COOLDOWN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    // Sensor bit order: 0 lvl_l, 1 lvl_m, 2 lvl_h, 3 soil_dry, 4 temp_high
    logic [NS-1:0]   raw;
    logic [NS-1:0]   sync1;
    logic [NS-1:0]   sync2;
    logic [NS-1:0]   filt;
    logic [DB_W-1:0] db_cnt [NS];
    logic            en_s1;
    logic            en_s2;

    state_t          state;
    state_t          next_state;
    logic [CNT_W-1:0] on_cnt;
    logic [CNT_W-1:0] cooldown;
    logic            fill_q;

    logic lvl_l_f;
    logic lvl_m_f;
    logic lvl_h_f;
    logic soil_dry_f;
    logic temp_high_f;
    logic incons;
    logic watering;
    logic next_watering;

    assign raw = {temp_high, soil_dry, lvl_h, lvl_m, lvl_l};

    assign lvl_l_f     = filt[0];
    assign lvl_m_f     = filt[1];
    assign lvl_h_f     = filt[2];
    assign soil_dry_f  = filt[3];
    assign temp_high_f = filt[4];

    // A higher probe reading water while a lower one reads dry means a broken probe
    assign incons = (lvl_h_f & ~lvl_m_f) | (lvl_m_f & ~lvl_l_f);

    assign watering      = (state == ST_SPRINKLE) || (state == ST_DRIP);
    assign next_watering = (next_state == ST_SPRINKLE) || (next_state == ST_DRIP);

    // Two-stage synchronizers for all asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            en_s1 <= 1'b0;
            en_s2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            en_s1 <= enable;
            en_s2 <= en_s1;
        end
    end

    // Filtered value follows the synchronized one only after a run of disagreeing edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= '0;
            for (int i = 0; i < NS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Next-mode decision; fault detection outranks every other rule
    always_comb begin
        next_state = state;
        if (incons) begin
            next_state = ST_FAULT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en_s2 && soil_dry_f && lvl_l_f && (cooldown == '0)) begin
                        next_state = temp_high_f ? ST_DRIP : ST_SPRINKLE;
                    end
                end
                ST_SPRINKLE, ST_DRIP: begin
                    if (!en_s2 || !lvl_l_f) begin
                        next_state = ST_IDLE;
                    end else if (on_cnt == ON_MAX_LAST) begin
                        next_state = ST_IDLE;
                    end else if (!soil_dry_f && (on_cnt >= ON_MIN_LAST)) begin
                        next_state = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (!en_s2) begin
                        next_state = ST_IDLE;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Mode register, on-time and cooldown counters, hysteretic fill valve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            on_cnt   <= '0;
            cooldown <= '0;
            fill_q   <= 1'b0;
        end else begin
            state <= next_state;

            if (!watering && next_watering) begin
                on_cnt <= '0;
            end else if (watering && (on_cnt != CNT_SAT)) begin
                on_cnt <= on_cnt + 1'b1;
            end

            if (next_state == ST_FAULT) begin
                cooldown <= '0;
            end else if (watering && (next_state == ST_IDLE)) begin
                cooldown <= COOL_LOAD;
            end else if ((state == ST_IDLE) && (cooldown != '0)) begin
                cooldown <= cooldown - 1'b1;
            end

            if (next_state == ST_FAULT) begin
                fill_q <= 1'b0;
            end else if (!lvl_m_f) begin
                fill_q <= 1'b1;
            end else if (lvl_h_f) begin
                fill_q <= 1'b0;
            end
        end
    end

    // Outputs decode the mode register only, so reset clears them immediately
    assign sel          = state;
    assign sprinkler_en = (state == ST_SPRINKLE);
    assign drip_en      = (state == ST_DRIP);
    assign alarm        = (state == ST_FAULT);
    assign fill_valve   = fill_q;

endmodule

// File: tb/tb_irrigation_mode_fsm.sv
// tb/tb_irrigation_mode_fsm.sv - self-checking bench for irrigation_mode_fsm
module tb_irrigation_mode_fsm;

    localparam int DEB  = 4;
    localparam int MINO = 16;
    localparam int MAXO = 200;
    localparam int COOL = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       lvl_l = 1'b0;
    logic       lvl_m = 1'b0;
    logic       lvl_h = 1'b0;
    logic       soil_dry = 1'b0;
    logic       temp_high = 1'b0;
    logic [1:0] sel;
    logic       sprinkler_en;
    logic       drip_en;
    logic       fill_valve;
    logic       alarm;

    int n_pass = 0;
    int n_total = 0;
    bit chk_on = 1'b0;

    irrigation_mode_fsm #(
        .DEBOUNCE_CYCLES(DEB),
        .MIN_ON_CYCLES(MINO),
        .MAX_ON_CYCLES(MAXO),
        .COOLDOWN_CYCLES(COOL),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .lvl_l(lvl_l),
        .lvl_m(lvl_m),
        .lvl_h(lvl_h),
        .soil_dry(soil_dry),
        .temp_high(temp_high),
        .sel(sel),
        .sprinkler_en(sprinkler_en),
        .drip_en(drip_en),
        .fill_valve(fill_valve),
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 sprinkle, 2 drip, 3 fault
    int m_mode = 0;
    int m_on = 0;
    int m_cool = 0;
    bit m_fill = 0;
    bit m_e1 = 0;
    bit m_e2 = 0;
    bit [4:0] m_s1 = '0;
    bit [4:0] m_s2 = '0;
    bit [4:0] m_filt = '0;
    int m_run [5];
    bit lo, mid, hi, dry, hot, bad;
    int nxt;
    bit [4:0] rawv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_on = 0; m_cool = 0; m_fill = 0;
            m_e1 = 0; m_e2 = 0; m_s1 = '0; m_s2 = '0; m_filt = '0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
        end else begin
            lo = m_filt[0]; mid = m_filt[1]; hi = m_filt[2];
            dry = m_filt[3]; hot = m_filt[4];
            bad = (hi && !mid) || (mid && !lo);
            nxt = m_mode;
            if (bad) nxt = 3;
            else if (m_mode == 0) begin
                if (m_e2 && dry && lo && m_cool == 0) nxt = hot ? 2 : 1;
            end else if (m_mode == 1 || m_mode == 2) begin
                if (!m_e2 || !lo) nxt = 0;
                else if (m_on == MAXO - 1) nxt = 0;
                else if (!dry && m_on >= MINO - 1) nxt = 0;
            end else begin
                if (!m_e2) nxt = 0;
            end

            if (nxt == 3) m_fill = 0;
            else if (!mid) m_fill = 1;
            else if (hi) m_fill = 0;

            if (nxt == 3) m_cool = 0;
            else if ((m_mode == 1 || m_mode == 2) && nxt == 0) m_cool = COOL;
            else if (m_mode == 0 && m_cool > 0) m_cool = m_cool - 1;

            if (m_mode == 0 || m_mode == 3) m_on = 0;
            else if (m_on < 255) m_on = m_on + 1;

            for (int i = 0; i < 5; i++) begin
                if (m_s2[i] != m_filt[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB) begin
                        m_filt[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            rawv = {temp_high, soil_dry, lvl_h, lvl_m, lvl_l};
            m_s2 = m_s1;
            m_s1 = rawv;
            m_e2 = m_e1;
            m_e1 = enable;
            m_mode = nxt;
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            n_total++;
            if (sel !== m_mode[1:0] || sprinkler_en !== (m_mode == 1) ||
                drip_en !== (m_mode == 2) || alarm !== (m_mode == 3) ||
                fill_valve !== m_fill) begin
                $display("FAIL model_cycle t=%0t: got sel=%b spr=%b drip=%b fill=%b alarm=%b, expected sel=%0d fill=%b",
                         $time, sel, sprinkler_en, drip_en, fill_valve, alarm, m_mode, m_fill);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic wait_sel(input logic [1:0] code, input int budget, output int k);
        k = 0;
        while (sel !== code && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic count_in(input logic [1:0] code, input int budget, output int n);
        n = 0;
        while (sel === code && n < budget) begin
            n++;
            @(negedge clk);
        end
    endtask

    int k;
    int n;

    initial begin
        tick(2);
        check("reset_sel", sel, 0);
        check("reset_sprinkler", sprinkler_en, 0);
        check("reset_drip", drip_en, 0);
        check("reset_fill", fill_valve, 0);
        check("reset_alarm", alarm, 0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        enable = 1; lvl_l = 1; lvl_m = 1; lvl_h = 1; temp_high = 0; soil_dry = 0;
        tick(20);
        check("fill_cleared_by_high", fill_valve, 0);

        // Sprinkler start latency and soil-wet exit held by the minimum on-time
        soil_dry = 1;
        wait_sel(2'b01, 30, k);
        check("sprinkle_start_latency", k, DEB + 3);
        tick(3);
        soil_dry = 0;
        count_in(2'b01, 300, n);
        check("sprinkle_min_on_cycles", n + 3, MINO);

        // Drip timeout and cooldown before restart
        temp_high = 1;
        tick(15);
        soil_dry = 1;
        wait_sel(2'b10, 30, k);
        check("drip_entered", sel, 2);
        count_in(2'b10, 400, n);
        check("drip_timeout_cycles", n, MAXO);
        count_in(2'b00, 50, n);
        check("restart_gap_at_least_cooldown", int'(n >= COOL), 1);
        check("drip_restarted", sel, 2);
        enable = 0;
        tick(5);
        check("enable_drop_stops", sel, 0);
        soil_dry = 0; temp_high = 0; enable = 1;
        tick(20);

        // Debounce: 3-cycle pulse ignored, 4-cycle pulse honoured
        soil_dry = 1;
        tick(3);
        soil_dry = 0;
        wait_sel(2'b01, 15, k);
        check("short_pulse_ignored", sel, 0);
        soil_dry = 1;
        tick(4);
        soil_dry = 0;
        wait_sel(2'b01, 15, k);
        check("long_pulse_starts", sel, 1);
        count_in(2'b01, 40, n);
        tick(20);

        // Tank empties mid-watering
        lvl_h = 0;
        tick(10);
        check("fill_holds_low", fill_valve, 0);
        soil_dry = 1;
        wait_sel(2'b01, 30, k);
        check("tank_test_started", sel, 1);
        tick(5);
        lvl_l = 0; lvl_m = 0;
        count_in(2'b01, 40, n);
        check("tank_empty_on_cycles", n + 5, 5 + DEB + 3);
        check("tank_empty_idle", sel, 0);
        check("fill_opens_on_low_mid", fill_valve, 1);
        soil_dry = 0; lvl_l = 1; lvl_m = 1;
        tick(12);
        check("fill_holds_open", fill_valve, 1);
        lvl_h = 1;
        tick(10);
        check("fill_closes_on_high", fill_valve, 0);

        // Fault and acknowledge
        lvl_m = 0;
        tick(10);
        check("fault_sel", sel, 3);
        check("fault_alarm", alarm, 1);
        check("fault_fill", fill_valve, 0);
        lvl_m = 1;
        tick(12);
        check("fault_held_while_enabled", sel, 3);
        enable = 0;
        tick(6);
        check("fault_ack_sel", sel, 0);
        check("fault_ack_alarm", alarm, 0);

        // Async reset mid-drip
        enable = 1; temp_high = 1; soil_dry = 1;
        wait_sel(2'b10, 40, k);
        check("drip_before_reset", sel, 2);
        tick(5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_sel", sel, 0);
        check("async_reset_drip", drip_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_sel(2'b10, 30, k);
        check("restart_after_reset_latency", k, DEB + 3);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                rawv[2:0] = 3'($urandom_range(0, 7));
                lvl_l = rawv[0]; lvl_m = rawv[1]; lvl_h = rawv[2];
            end
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            if ($urandom_range(0, 7) == 0) soil_dry = ~soil_dry;
            if ($urandom_range(0, 19) == 0) temp_high = ~temp_high;
        end
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
